// File: rtl/counter_sequencer.sv
// Command-driven sequencer for an up/down step counter: loads, runs and re-arms the counter
// for one-shot, auto-reload and ping-pong runs, reporting done, hit count and error status.
module counter_sequencer #(
    parameter int CNT_WIDTH    = 8,
    parameter int CNT_MAX      = 20,
    parameter int CNT_MIN      = 2,
    parameter int STALL_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_start,
    input  logic [3:0]           cmd_step,
    input  logic                 cmd_dir,
    input  logic [1:0]           cmd_mode,
    input  logic [7:0]           cmd_reps,
    input  logic                 abort,
    output logic                 cnt_en,
    output logic                 cnt_set,
    output logic [3:0]           cnt_din,
    output logic [3:0]           cnt_step,
    output logic                 cnt_up_down,
    input  logic [CNT_WIDTH-1:0] cnt_count,
    input  logic                 cnt_finish,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err,
    output logic [7:0]           hits,
    output logic                 finish_seen
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_STALL = 2'b01, ERR_ABORT = 2'b10} err_t;

    typedef struct packed {
        logic ready;
        logic busy;
        logic en;
        logic set;
        logic done;
    } moore_t;

    localparam logic [1:0]           MODE_RELOAD = 2'b01;
    localparam logic [1:0]           MODE_PINGPONG = 2'b10;
    localparam int                   STALL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [STALL_W-1:0]   STALL_LIMIT = STALL_W'(STALL_CYCLES);
    localparam logic [CNT_WIDTH-1:0] MAX_V = CNT_WIDTH'(CNT_MAX);
    localparam logic [CNT_WIDTH-1:0] MIN_V = CNT_WIDTH'(CNT_MIN);

    state_t               state;
    moore_t               outs;
    err_t                 err_q;
    logic [3:0]           start_q;
    logic [3:0]           step_q;
    logic                 dir_q;
    logic [1:0]           mode_q;
    logic [7:0]           reps_q;
    logic [7:0]           hits_q;
    logic                 finish_q;
    logic [STALL_W-1:0]   stall_cnt;
    logic [CNT_WIDTH-1:0] prev_count;
    logic                 run_first;

    logic                 hit;
    logic [7:0]           reps_eff;
    logic [7:0]           hits_inc;
    logic [STALL_W-1:0]   stall_next;

    // Outputs are the registered Moore decode of the state being entered.
    function automatic moore_t decode(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            IDLE: m.ready = 1'b1;
            LOAD: begin m.busy = 1'b1; m.en = 1'b1; m.set = 1'b1; end
            RUN:  begin m.busy = 1'b1; m.en = 1'b1; end
            DONE: begin m.busy = 1'b1; m.done = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

    // Limit detection uses the live count, never cnt_finish, which goes stale after a flip.
    assign hit        = dir_q ? (cnt_count >= MAX_V) : (cnt_count <= MIN_V);
    assign reps_eff   = (reps_q == 8'd0) ? 8'd1 : reps_q;
    assign hits_inc   = (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;
    assign stall_next = stall_cnt + STALL_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            outs       <= '0;
            err_q      <= ERR_OK;
            start_q    <= '0;
            step_q     <= '0;
            dir_q      <= 1'b0;
            mode_q     <= '0;
            reps_q     <= '0;
            hits_q     <= '0;
            finish_q   <= 1'b0;
            stall_cnt  <= '0;
            prev_count <= '0;
            run_first  <= 1'b0;
        end else begin
            // NOTE: later non-blocking assignments in this block override these defaults.
            outs <= decode(state);
            case (state)
                IDLE: begin
                    if (cmd_valid && outs.ready) begin
                        start_q  <= cmd_start;
                        step_q   <= cmd_step;
                        dir_q    <= cmd_dir;
                        mode_q   <= cmd_mode;
                        reps_q   <= cmd_reps;
                        hits_q   <= '0;
                        err_q    <= ERR_OK;
                        finish_q <= 1'b0;
                        state    <= LOAD;
                        outs     <= decode(LOAD);
                    end
                end
                LOAD: begin
                    stall_cnt <= '0;
                    run_first <= 1'b1;
                    if (abort) begin
                        err_q <= ERR_ABORT;
                        state <= DONE;
                        outs  <= decode(DONE);
                    end else begin
                        state <= RUN;
                        outs  <= decode(RUN);
                    end
                end
                RUN: begin
                    run_first  <= 1'b0;
                    prev_count <= cnt_count;
                    if (cnt_finish) finish_q <= 1'b1;
                    if (abort) begin
                        err_q <= ERR_ABORT;
                        state <= DONE;
                        outs  <= decode(DONE);
                    end else if (hit) begin
                        stall_cnt <= '0;
                        hits_q    <= hits_inc;
                        if ((mode_q == MODE_RELOAD || mode_q == MODE_PINGPONG) && hits_inc < reps_eff) begin
                            if (mode_q == MODE_RELOAD) begin
                                state <= LOAD;
                                outs  <= decode(LOAD);
                            end else begin
                                dir_q <= ~dir_q;
                            end
                        end else begin
                            state <= DONE;
                            outs  <= decode(DONE);
                        end
                    end else if (!run_first && cnt_count == prev_count) begin
                        if (stall_next == STALL_LIMIT) begin
                            err_q <= ERR_STALL;
                            state <= DONE;
                            outs  <= decode(DONE);
                        end else begin
                            stall_cnt <= stall_next;
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    outs  <= decode(IDLE);
                end
                default: begin
                    state <= IDLE;
                    outs  <= decode(IDLE);
                end
            endcase
        end
    end

    assign cmd_ready   = outs.ready;
    assign busy        = outs.busy;
    assign cnt_en      = outs.en;
    assign cnt_set     = outs.set;
    assign done        = outs.done;
    assign cnt_din     = start_q;
    assign cnt_step    = step_q;
    assign cnt_up_down = dir_q;
    assign err         = err_q;
    assign hits        = hits_q;
    assign finish_seen = finish_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer, driving a behavioural up/down step counter
// (MAX=20, MIN=2, holds at the limit in its direction of travel).
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_start;
    logic [3:0] cmd_step;
    logic       cmd_dir;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_reps;
    logic       abort;
    logic       cnt_en;
    logic       cnt_set;
    logic [3:0] cnt_din;
    logic [3:0] cnt_step;
    logic       cnt_up_down;
    logic [7:0] cnt_count;
    logic       cnt_finish;
    logic       busy;
    logic       done;
    logic [1:0] err;
    logic [7:0] hits;
    logic       finish_seen;

    int total = 0;
    int bad = 0;
    logic [7:0] obs_count [0:127];

    counter_sequencer #(
        .CNT_WIDTH(8), .CNT_MAX(20), .CNT_MIN(2), .STALL_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_step(cmd_step), .cmd_dir(cmd_dir),
        .cmd_mode(cmd_mode), .cmd_reps(cmd_reps), .abort(abort),
        .cnt_en(cnt_en), .cnt_set(cnt_set), .cnt_din(cnt_din), .cnt_step(cnt_step),
        .cnt_up_down(cnt_up_down), .cnt_count(cnt_count), .cnt_finish(cnt_finish),
        .busy(busy), .done(done), .err(err), .hits(hits), .finish_seen(finish_seen)
    );

    always #5 clk = ~clk;

    // Downstream counter model.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_count <= 8'd0;
        end else if (cnt_en) begin
            if (cnt_set) begin
                cnt_count <= {4'd0, cnt_din};
            end else if (cnt_up_down) begin
                if (cnt_count < 8'd20) cnt_count <= cnt_count + {4'd0, cnt_step};
            end else if (cnt_count > 8'd2) begin
                cnt_count <= (cnt_count > {4'd0, cnt_step}) ? cnt_count - {4'd0, cnt_step} : 8'd0;
            end
        end
    end

    assign cnt_finish = cnt_up_down ? (cnt_count >= 8'd20) : (cnt_count <= 8'd2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns in the LOAD cycle (T+1).
    task automatic issue(input logic [3:0] st, input logic [3:0] sp, input logic d,
                         input logic [1:0] m, input logic [7:0] r);
        int n;
        cmd_start = st; cmd_step = sp; cmd_dir = d; cmd_mode = m; cmd_reps = r;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_wait: cmd_ready=%b, expected 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Runs one command; done_off is the cycle offset from the accept cycle T at which done is seen.
    task automatic run_cmd(input logic [3:0] st, input logic [3:0] sp, input logic d,
                           input logic [1:0] m, input logic [7:0] r, input int abort_off,
                           output int done_off, output int sets, output int flips);
        int n;
        logic prev_dir;
        issue(st, sp, d, m, r);
        n = 1;
        sets = 0;
        flips = 0;
        prev_dir = cnt_up_down;
        while (done !== 1'b1 && n < 100) begin
            if (cnt_set === 1'b1) sets++;
            if (cnt_up_down !== prev_dir) flips++;
            prev_dir = cnt_up_down;
            obs_count[n] = cnt_count;
            abort = (n == abort_off);
            tick();
            n++;
        end
        abort = 1'b0;
        done_off = (done === 1'b1) ? n : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        cmd_start = '0; cmd_step = '0; cmd_dir = 1'b0; cmd_mode = '0; cmd_reps = '0;
        repeat (3) tick();
        total++;
        if ({cmd_ready, busy, done, cnt_en, cnt_set, err, hits, finish_seen} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b busy=%b done=%b en=%b set=%b err=%b hits=%0d fs=%b, expected all 0",
                     cmd_ready, busy, done, cnt_en, cnt_set, err, hits, finish_seen);
        end
        rst = 1'b0;
        tick();
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b busy=%b, expected 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_one_shot(input logic [1:0] m, input string tag);
        int off, sets, flips;
        run_cmd(4'd4, 4'd3, 1'b1, m, 8'd1, 0, off, sets, flips);
        total++;
        if (off !== 9) begin bad++; $display("FAIL %s_done_cycle: got T+%0d, expected T+9", tag, off); end
        total++;
        if (hits !== 8'd1 || err !== 2'b00) begin
            bad++; $display("FAIL %s_status: hits=%0d err=%b, expected 1/00", tag, hits, err);
        end
        total++;
        if (finish_seen !== 1'b1) begin bad++; $display("FAIL %s_finish_seen: got %b, expected 1", tag, finish_seen); end
        for (int i = 2; i <= 8; i++) begin
            total++;
            if (obs_count[i] !== 8'(4 + 3 * (i - 2))) begin
                bad++;
                $display("FAIL %s_count_T%0d: got %0d, expected %0d", tag, i, obs_count[i], 4 + 3 * (i - 2));
            end
        end
    endtask

    task automatic test_ping_pong();
        int off, sets, flips;
        run_cmd(4'd10, 4'd5, 1'b0, 2'b10, 8'd3, 0, off, sets, flips);
        total++;
        if (off !== 15) begin bad++; $display("FAIL pingpong_done_cycle: got T+%0d, expected T+15", off); end
        total++;
        if (hits !== 8'd3 || err !== 2'b00) begin
            bad++; $display("FAIL pingpong_status: hits=%0d err=%b, expected 3/00", hits, err);
        end
        total++;
        if (flips !== 2) begin bad++; $display("FAIL pingpong_flips: got %0d, expected 2", flips); end
        total++;
        if (obs_count[9] !== 8'd20 || obs_count[10] !== 8'd20 || obs_count[14] !== 8'd0) begin
            bad++;
            $display("FAIL pingpong_turns: T+9=%0d T+10=%0d T+14=%0d, expected 20/20/0",
                     obs_count[9], obs_count[10], obs_count[14]);
        end
    endtask

    task automatic test_reload(input logic [7:0] reps, input int exp_off, input int exp_sets,
                               input logic [7:0] exp_hits, input string tag);
        int off, sets, flips;
        run_cmd(4'd15, 4'd4, 1'b1, 2'b01, reps, 0, off, sets, flips);
        total++;
        if (off !== exp_off) begin bad++; $display("FAIL %s_done_cycle: got T+%0d, expected T+%0d", tag, off, exp_off); end
        total++;
        if (sets !== exp_sets) begin bad++; $display("FAIL %s_set_count: got %0d, expected %0d", tag, sets, exp_sets); end
        total++;
        if (hits !== exp_hits || err !== 2'b00) begin
            bad++; $display("FAIL %s_status: hits=%0d err=%b, expected %0d/00", tag, hits, err, exp_hits);
        end
    endtask

    task automatic test_stall();
        int off, sets, flips;
        run_cmd(4'd9, 4'd0, 1'b1, 2'b00, 8'd1, 0, off, sets, flips);
        total++;
        if (off !== 11) begin bad++; $display("FAIL stall_done_cycle: got T+%0d, expected T+11", off); end
        total++;
        if (err !== 2'b01 || hits !== 8'd0) begin
            bad++; $display("FAIL stall_status: err=%b hits=%0d, expected 01/0", err, hits);
        end
    endtask

    task automatic test_abort();
        int off, sets, flips;
        run_cmd(4'd4, 4'd3, 1'b1, 2'b00, 8'd1, 5, off, sets, flips);
        total++;
        if (obs_count[5] !== 8'd13 || off !== 6) begin
            bad++; $display("FAIL abort_timing: count=%0d done=T+%0d, expected 13/T+6", obs_count[5], off);
        end
        total++;
        if (err !== 2'b10 || cnt_en !== 1'b0) begin
            bad++; $display("FAIL abort_done_state: err=%b en=%b, expected 10/0", err, cnt_en);
        end
        tick();
        total++;
        if (cnt_en !== 1'b0 || busy !== 1'b0 || err !== 2'b10) begin
            bad++; $display("FAIL abort_idle_state: en=%b busy=%b err=%b, expected 0/0/10", cnt_en, busy, err);
        end
        run_cmd(4'd4, 4'd3, 1'b1, 2'b00, 8'd1, 8, off, sets, flips);
        total++;
        if (off !== 9 || err !== 2'b10) begin
            bad++; $display("FAIL abort_with_hit: done=T+%0d err=%b, expected T+9/10", off, err);
        end
    endtask

    task automatic test_rst_mid_run();
        issue(4'd4, 4'd3, 1'b1, 2'b00, 8'd1);
        tick();
        tick();
        total++;
        if (busy !== 1'b1 || cnt_en !== 1'b1) begin
            bad++; $display("FAIL midrun_running: busy=%b en=%b, expected 1/1", busy, cnt_en);
        end
        rst = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || cnt_en !== 1'b0 || hits !== 8'd0 || err !== 2'b00) begin
            bad++; $display("FAIL midrun_in_reset: busy=%b en=%b hits=%0d err=%b, expected 0/0/0/00",
                            busy, cnt_en, hits, err);
        end
        rst = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL midrun_release: busy=%b ready=%b, expected 0/1", busy, cmd_ready);
        end
        test_one_shot(2'b00, "after_rst");
    endtask

    initial begin
        test_reset();
        test_one_shot(2'b00, "oneshot");
        test_one_shot(2'b11, "mode3");
        test_ping_pong();
        test_reload(8'd2, 9, 2, 8'd2, "reload");
        test_reload(8'd0, 5, 1, 8'd1, "reload_reps0");
        test_stall();
        test_abort();
        test_rst_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
